// File: rtl/booth_pp_stream.sv
// booth_pp_stream
//   Sequential radix-4 Booth partial-product generator. One signed a/b pair
//   is accepted, then one partial product per cycle is emitted, least
//   significant digit first. Downstream weights product i by 4^i.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready_o high
//   EMIT  | presenting digit idx_q of the latched multiplier
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   in_valid_i      operand pair offered        in_ready_o   pair accepted
//   a_i [WA]        signed multiplicand         b_i [WB]     signed multiplier
//   out_valid_o     partial product valid       out_ready_i  downstream takes it
//   pp_o [WA+2]     digit x a, sign-extended    pp_idx_o     digit index
//   pp_digit_o [3]  signed Booth digit          pp_last_o    final digit
module booth_pp_stream #(
    parameter  int WA = 6,
    parameter  int WB = 6,
    localparam int N  = WB / 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [WA-1:0] a_i,
    input  logic [WB-1:0] b_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [WA+1:0] pp_o,
    output logic [IW-1:0] pp_idx_o,
    output logic [2:0]    pp_digit_o,
    output logic          pp_last_o
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [WA-1:0] a_q, a_d;
    logic [WB:0]   b_q, b_d;     // {b, 1'b0}: bit 0 is the implicit b[-1]
    logic [IW-1:0] idx_q, idx_d;

    logic          emit;
    logic          is_last;
    logic [2:0]    digit;
    logic [WA+1:0] a_ext;
    logic [WA+1:0] a_x2;
    logic [WA+1:0] pp_val;

    assign emit    = (state_q == EMIT);
    assign is_last = emit && (idx_q == LAST_IDX);

    // Two extra bits give room for -2 * (-2^(WA-1)) = +2^WA.
    assign a_ext = {{2{a_q[WA-1]}}, a_q};
    assign a_x2  = {a_q[WA-1], a_q, 1'b0};

    always_comb begin
        digit = 3'b000;
        case (b_q[2:0])
            3'b001, 3'b010: digit = 3'b001;   // +1
            3'b011:         digit = 3'b010;   // +2
            3'b100:         digit = 3'b110;   // -2
            3'b101, 3'b110: digit = 3'b111;   // -1
            default:        digit = 3'b000;
        endcase
    end

    always_comb begin
        pp_val = '0;
        case (digit)
            3'b001:  pp_val = a_ext;
            3'b010:  pp_val = a_x2;
            3'b111:  pp_val = -a_ext;
            3'b110:  pp_val = -a_x2;
            default: pp_val = '0;
        endcase
    end

    // Outputs depend only on registered state; zeroed while idle.
    assign pp_o       = emit ? pp_val : '0;
    assign pp_digit_o = emit ? digit  : 3'b000;
    assign pp_idx_o   = emit ? idx_q  : '0;
    assign pp_last_o  = is_last;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = {b_i, 1'b0};
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        b_d   = {{2{b_q[WB]}}, b_q[WB:2]};
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    end

endmodule
